// File: rtl/mem_exec_unit.sv
// mem_exec_unit: in-order memory functional unit with an input FIFO, a private 8x3 data memory
// with fixed access latency, and a request/grant CDB write-back port.
module mem_exec_unit #(
    parameter int FIFO_DEPTH = 2,
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [2:0] issue_opcode,
    input  logic [2:0] issue_val1,
    input  logic [1:0] issue_rob_idx,
    output logic       fu_full,
    output logic       cdb_req,
    input  logic       cdb_grant,
    output logic       cdb_en,
    output logic [1:0] cdb_rob_idx,
    output logic [2:0] cdb_val,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MEM_LAT) + 1;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    state_t        state, state_n;
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;
    logic [2:0]    op_code, op_val, cur, result;
    logic [1:0]    op_tag;
    logic [2:0]    mem [8];
    logic          pop, push, done, mem_we;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pop     = state == IDLE && count != '0;
    assign push    = issue_valid && (count != FULL || pop);
    assign fu_full = count == FULL;
    assign done    = state == ACCESS && cnt == '0;
    assign cdb_req = state == WB;
    assign cdb_en  = cdb_req && cdb_grant;

    // The written value equals the result for every op that modifies memory.
    assign cur    = mem[op_val];
    assign result = op_code == 3'b001 ? cur :
                    op_code == 3'b010 ? cur + 3'd1 :
                    op_code == 3'b011 ? 3'd0 : op_val;
    assign mem_we = op_code inside {3'b010, 3'b011, 3'b100};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = pop ? ACCESS : IDLE;
            ACCESS:  state_n = done ? WB : ACCESS;
            WB:      state_n = cdb_grant ? IDLE : WB;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= {issue_opcode, issue_val1, issue_rob_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cnt         <= '0;
            op_code     <= '0;
            op_val      <= '0;
            op_tag      <= '0;
            cdb_val     <= '0;
            cdb_rob_idx <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                      <= rd_ptr + 1'b1;
                {op_code, op_val, op_tag}   <= fifo[rd_ptr];
                cnt                         <= LAT_M1;
            end else if (state == ACCESS && !done) begin
                cnt <= cnt - 1'b1;
            end
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (issue_valid && !push) overflow <= 1'b1;
            if (done) begin
                cdb_val     <= result;
                cdb_rob_idx <= op_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 3'(i);
        end else if (done && mem_we) begin
            mem[op_val] <= result;
        end
    end
endmodule

// File: tb/tb_mem_exec_unit.sv
// tb_mem_exec_unit: scoreboard bench; a reference memory model predicts each result at issue time
// and a monitor checks every CDB broadcast against the queued expectation in order.
module tb_mem_exec_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [2:0] issue_opcode = '0;
    logic [2:0] issue_val1 = '0;
    logic [1:0] issue_rob_idx = '0;
    logic       fu_full, cdb_req, cdb_en, overflow;
    logic       cdb_grant = 1'b0;
    logic [1:0] cdb_rob_idx;
    logic [2:0] cdb_val;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] mdl [8];
    logic [4:0] sb [$];

    mem_exec_unit #(.FIFO_DEPTH(2), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_val1(issue_val1), .issue_rob_idx(issue_rob_idx), .fu_full(fu_full),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_en(cdb_en),
        .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] model(input logic [2:0] op, input logic [2:0] a);
        case (op)
            3'b001:  return mdl[a];
            3'b010:  begin mdl[a] = mdl[a] + 3'd1; return mdl[a]; end
            3'b011:  begin mdl[a] = 3'd0; return 3'd0; end
            3'b100:  begin mdl[a] = a; return a; end
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 3'(i);
        sb.delete();
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst_n && cdb_en) begin
            if (sb.size() == 0) begin
                check("cdb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("cdb_val", int'(cdb_val), int'(e[2:0]));
                check("cdb_tag", int'(cdb_rob_idx), int'(e[4:3]));
            end
        end
    end

    // All tasks below start and end one time unit after a rising edge.
    task automatic drive(input logic [2:0] op, input logic [2:0] a, input logic [1:0] t,
                         input bit acc);
        issue_valid = 1'b1;
        issue_opcode = op;
        issue_val1 = a;
        issue_rob_idx = t;
        if (acc) sb.push_back({t, model(op, a)});
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [1:0] t);
        int n = 0;
        while (fu_full && n < 100) begin @(posedge clk); #1; n++; end
        if (fu_full) check("issue_timeout", 1, 0);
        drive(op, a, t, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        check("drain_left", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!cdb_req && n < 50) begin @(posedge clk); #1; n++; end
        check("req_timeout", int'(cdb_req), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        cdb_grant = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_full", int'(fu_full), 0);
        check("rst_req", int'(cdb_req), 0);
        check("rst_en", int'(cdb_en), 0);
        check("rst_tag", int'(cdb_rob_idx), 0);
        check("rst_val", int'(cdb_val), 0);
        check("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: issue in cycle 0, request only in cycle 4 with grant tied high.
        issue_valid = 1'b1;
        issue_opcode = 3'b001;
        issue_val1 = 3'd5;
        issue_rob_idx = 2'd2;
        sb.push_back({2'd2, model(3'b001, 3'd5)});
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("lat_req", int'(cdb_req), int'(c == 4));
            check("lat_en", int'(cdb_en), int'(c == 4));
            if (c == 0) begin @(posedge clk); #1 issue_valid = 1'b0; end
        end
        @(posedge clk); #1;

        // Wrap on INC, CLR then reload.
        issue(3'b010, 3'd7, 2'd1);
        issue(3'b001, 3'd7, 2'd3);
        issue(3'b011, 3'd3, 2'd0);
        issue(3'b001, 3'd3, 2'd1);
        drain();

        // Held in WB without grant.
        cdb_grant = 1'b0;
        issue(3'b111, 3'd6, 2'd2);
        wait_req();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stall_req", int'(cdb_req), 1);
            check("stall_val", int'(cdb_val), 6);
            check("stall_tag", int'(cdb_rob_idx), 2);
        end
        @(posedge clk); #1 cdb_grant = 1'b1;
        @(negedge clk);
        check("grant_en", int'(cdb_en), 1);
        @(posedge clk); #1 cdb_grant = 1'b0;
        @(negedge clk);
        check("post_grant_req", int'(cdb_req), 0);
        check("post_grant_en", int'(cdb_en), 0);
        @(posedge clk); #1;

        // Fill FIFO while stalled, fourth issue is dropped.
        drive(3'b100, 3'd2, 2'd0, 1'b1);
        drive(3'b010, 3'd2, 2'd1, 1'b1);
        drive(3'b001, 3'd2, 2'd2, 1'b1);
        check("fill_full", int'(fu_full), 1);
        check("fill_ovf_pre", int'(overflow), 0);
        drive(3'b011, 3'd2, 2'd3, 1'b0);
        check("ovf_set", int'(overflow), 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_full", int'(fu_full), 1);
        cdb_grant = 1'b1;
        drain();
        issue(3'b001, 3'd2, 2'd1);
        drain();
        check("ovf_keep", int'(overflow), 1);

        // Full FIFO plus issue in the cycle the head is popped.
        do_reset();
        check("reset_ovf_clr", int'(overflow), 0);
        cdb_grant = 1'b0;
        drive(3'b111, 3'd5, 2'd0, 1'b1);
        wait_req();
        drive(3'b010, 3'd4, 2'd1, 1'b1);
        drive(3'b001, 3'd4, 2'd2, 1'b1);
        check("pp_full", int'(fu_full), 1);
        cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
        check("pp_idle_full", int'(fu_full), 1);
        drive(3'b100, 3'd1, 2'd3, 1'b1);
        check("pp_count", int'(fu_full), 1);
        check("pp_ovf", int'(overflow), 0);
        cdb_grant = 1'b1;
        drain();

        // Random ops with immediate grant.
        for (int i = 0; i < 12; i++)
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        drain();

        // Reset during ACCESS with two ops queued.
        cdb_grant = 1'b0;
        drive(3'b010, 3'd0, 2'd1, 1'b1);
        drive(3'b011, 3'd1, 2'd2, 1'b1);
        drive(3'b100, 3'd6, 2'd3, 1'b1);
        check("mid_full", int'(fu_full), 1);
        rst_n = 1'b0;
        #1;
        check("mid_req", int'(cdb_req), 0);
        check("mid_full_clr", int'(fu_full), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cdb_grant = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_req", int'(cdb_req), 0);
        for (int i = 0; i < 8; i++) issue(3'b001, 3'(i), 2'(i));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
